// File: rtl/mem_ctr_pkg.sv
// Shared definitions for the bus-2 line memory controller: C2 codes, FSM states
// and the beats-per-line helper.
package mem_ctr_pkg;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_WR_RECV,
        ST_WR_WAIT,
        ST_WR_RESP
    } state_e;

    function automatic int line_beats(input int line_bytes, input int bus_bits);
        return line_bytes * 8 / bus_bits;
    endfunction

endpackage

// File: rtl/mem_ctr_ram.sv
// Byte-lane RAM: asynchronous RD_BYTES-wide read port and a WR_BYTES-wide
// write port with one enable per byte lane. Contents are never reset.
module mem_ctr_ram #(
    parameter int MEM_SIZE = 524288,
    parameter int RD_BYTES = 2,
    parameter int WR_BYTES = 2,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic                    clk_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [8*RD_BYTES-1:0]   rd_data_o,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [WR_BYTES-1:0]     wr_be_i,
    input  logic [8*WR_BYTES-1:0]   wr_data_i
);

    logic [7:0] mem [MEM_SIZE];

    always_comb begin
        rd_data_o = '0;
        for (int unsigned k = 0; k < RD_BYTES; k++) begin
            rd_data_o[8*k +: 8] = mem[rd_addr_i + AW'(k)];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < WR_BYTES; k++) begin
            if (wr_be_i[k]) begin
                mem[wr_addr_i + AW'(k)] <= wr_data_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_ctr_line.sv
// Bus-2 memory controller serving whole-line READ/WRITE between cache and RAM.
// Define MEM_CTR_PARITY_EN to add per-byte odd parity (P2_IN/P2_OUT/ERR).
module mem_ctr_line
    import mem_ctr_pkg::*;
#(
    parameter int ADDR2_BUS_SIZE    = 15,
    parameter int DATA_BUS_SIZE     = 16,
    parameter int CTR2_BUS_SIZE     = 2,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int MEM_SIZE          = 524288,
    parameter int MEM_CTR_DELAY     = 100
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [ADDR2_BUS_SIZE-1:0]   A2_IN,
    input  logic [CTR2_BUS_SIZE-1:0]    C2_IN,
    output logic [CTR2_BUS_SIZE-1:0]    C2_OUT,
    output logic                        C2_OE,
    input  logic [DATA_BUS_SIZE-1:0]    D2_IN,
    output logic [DATA_BUS_SIZE-1:0]    D2_OUT,
    output logic                        D2_OE,
`ifdef MEM_CTR_PARITY_EN
    input  logic [DATA_BUS_SIZE/8-1:0]  P2_IN,
    output logic [DATA_BUS_SIZE/8-1:0]  P2_OUT,
    output logic                        ERR,
`endif
    output logic                        BUSY
);

    localparam int B     = DATA_BUS_SIZE / 8;
    localparam int BEATS = line_beats(CACHE_LINE_SIZE, DATA_BUS_SIZE);
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int CW    = $clog2(MEM_CTR_DELAY + BEATS + 1);
`ifdef MEM_CTR_PARITY_EN
    localparam int WB    = CACHE_LINE_SIZE;
`else
    localparam int WB    = B;
`endif

    localparam logic [CW-1:0] DLY_C    = CW'(MEM_CTR_DELAY);
    localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
    localparam logic [CW-1:0] RD_END_C = CW'(MEM_CTR_DELAY + BEATS);

    localparam logic [CTR2_BUS_SIZE-1:0] NOP_C  = CTR2_BUS_SIZE'(C2_NOP);
    localparam logic [CTR2_BUS_SIZE-1:0] RESP_C = CTR2_BUS_SIZE'(C2_RESPONSE);
    localparam logic [CTR2_BUS_SIZE-1:0] RD_C   = CTR2_BUS_SIZE'(C2_READ_LINE);
    localparam logic [CTR2_BUS_SIZE-1:0] WR_C   = CTR2_BUS_SIZE'(C2_WRITE_LINE);

    if (MEM_CTR_DELAY <= BEATS + 1 || DATA_BUS_SIZE % 8 != 0 || (1 << AW) != MEM_SIZE)
    begin : g_param_check
        $error("mem_ctr_line: MEM_CTR_DELAY must exceed BEATS+1, bus a byte multiple, MEM_SIZE a power of two");
    end

    state_e                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [AW-1:0]              base_q;
    logic [CTR2_BUS_SIZE-1:0]   c2_out_q;
    logic                       c2_oe_q;
    logic [DATA_BUS_SIZE-1:0]   d2_out_q;
    logic                       d2_oe_q;
    logic                       busy_q;

    logic                       is_rd, is_wr;
    logic [AW-1:0]              cmd_base, rd_addr, wr_addr;
    logic [DATA_BUS_SIZE-1:0]   rd_data;
    logic [WB-1:0]              wr_be;
    logic [8*WB-1:0]            wr_data;

`ifdef MEM_CTR_PARITY_EN
    logic [8*CACHE_LINE_SIZE-1:0] line_q;
    logic                         perr_q;
    logic                         err_q;
    logic [B-1:0]                 p2_out_q;

    function automatic logic [B-1:0] odd_par(input logic [DATA_BUS_SIZE-1:0] d);
        for (int unsigned k = 0; k < B; k++) begin
            odd_par[k] = ~^d[8*k +: 8];
        end
    endfunction
`endif

    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base, input logic [CW-1:0] idx);
        return base + AW'(idx) * AW'(B);
    endfunction

    // Line-aligned base; the cast truncates modulo MEM_SIZE so a line never straddles the wrap.
    assign cmd_base = AW'({A2_IN, {CACHE_OFFSET_SIZE{1'b0}}});
    assign is_rd    = (state_q == ST_IDLE) && (C2_IN == RD_C);
    assign is_wr    = (state_q == ST_IDLE) && (C2_IN == WR_C);
    assign rd_addr  = beat_addr(base_q, cnt_q - DLY_C);

    always_comb begin
        wr_be   = '0;
        wr_addr = beat_addr(base_q, cnt_q);
        wr_data = '0;
`ifdef MEM_CTR_PARITY_EN
        wr_addr = base_q;
        wr_data = line_q;
        if (state_q == ST_WR_WAIT && cnt_q == DLY_C && !perr_q) begin
            wr_be = '1;
        end
`else
        wr_data = D2_IN;
        if (is_wr) begin
            wr_be   = '1;
            wr_addr = cmd_base;
        end else if (state_q == ST_WR_RECV && cnt_q < BEATS_C) begin
            wr_be = '1;
        end
`endif
    end

    mem_ctr_ram #(
        .MEM_SIZE (MEM_SIZE),
        .RD_BYTES (B),
        .WR_BYTES (WB)
    ) u_ram (
        .clk_i     (CLK),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_addr_i (wr_addr),
        .wr_be_i   (wr_be),
        .wr_data_i (wr_data)
    );

    // cnt_q holds the index of the current edge counted from the command edge (edge 0).
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            c2_out_q <= NOP_C;
            c2_oe_q  <= 1'b0;
            d2_out_q <= '0;
            d2_oe_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MEM_CTR_PARITY_EN
            line_q   <= '0;
            perr_q   <= 1'b0;
            err_q    <= 1'b0;
            p2_out_q <= '0;
`endif
        end else begin
            busy_q <= (state_q != ST_IDLE);
            cnt_q  <= (state_q == ST_IDLE) ? CW'(1) : cnt_q + CW'(1);
            unique case (state_q)
                ST_IDLE: begin
                    if (is_rd) begin
                        state_q <= ST_RD_WAIT;
                        base_q  <= cmd_base;
                    end else if (is_wr) begin
                        state_q <= ST_WR_RECV;
                        base_q  <= cmd_base;
`ifdef MEM_CTR_PARITY_EN
                        line_q[DATA_BUS_SIZE-1:0] <= D2_IN;
                        perr_q <= (P2_IN != odd_par(D2_IN));
`endif
                    end
                end
                ST_RD_WAIT: begin
                    c2_oe_q <= 1'b1;
                    if (cnt_q == DLY_C) begin
                        state_q  <= ST_RD_SEND;
                        c2_out_q <= RESP_C;
                        d2_oe_q  <= 1'b1;
                        d2_out_q <= rd_data;
`ifdef MEM_CTR_PARITY_EN
                        p2_out_q <= odd_par(rd_data);
`endif
                    end else begin
                        c2_out_q <= NOP_C;
                    end
                end
                ST_RD_SEND: begin
                    if (cnt_q == RD_END_C) begin
                        state_q  <= ST_IDLE;
                        c2_oe_q  <= 1'b0;
                        c2_out_q <= NOP_C;
                        d2_oe_q  <= 1'b0;
                        d2_out_q <= '0;
`ifdef MEM_CTR_PARITY_EN
                        p2_out_q <= '0;
`endif
                    end else begin
                        d2_out_q <= rd_data;
`ifdef MEM_CTR_PARITY_EN
                        p2_out_q <= odd_par(rd_data);
`endif
                    end
                end
                ST_WR_RECV: begin
                    if (cnt_q == BEATS_C) begin
                        state_q  <= ST_WR_WAIT;
                        c2_oe_q  <= 1'b1;
                        c2_out_q <= NOP_C;
                    end else begin
`ifdef MEM_CTR_PARITY_EN
                        line_q[int'(cnt_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE] <= D2_IN;
                        perr_q <= perr_q | (P2_IN != odd_par(D2_IN));
`endif
                    end
                end
                ST_WR_WAIT: begin
                    if (cnt_q == DLY_C) begin
                        state_q  <= ST_WR_RESP;
                        c2_out_q <= RESP_C;
`ifdef MEM_CTR_PARITY_EN
                        err_q    <= perr_q;
`endif
                    end
                end
                ST_WR_RESP: begin
                    state_q  <= ST_IDLE;
                    c2_oe_q  <= 1'b0;
                    c2_out_q <= NOP_C;
`ifdef MEM_CTR_PARITY_EN
                    err_q    <= 1'b0;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign C2_OUT = c2_out_q;
    assign C2_OE  = c2_oe_q;
    assign D2_OUT = d2_out_q;
    assign D2_OE  = d2_oe_q;
    assign BUSY   = busy_q;
`ifdef MEM_CTR_PARITY_EN
    assign P2_OUT = p2_out_q;
    assign ERR    = err_q;
`endif

endmodule
